// File: rtl/itable_phase_sequencer.sv
// Opcode fetch / execution phase sequencer feeding the instruction decoder tree.
// Latches opcodes, absorbs IX/IY prefixes, steps XPT and returns to M1 on decoder strobes.
module itable_phase_sequencer #(
  parameter logic [7:0] PREFIX_IX = 8'hDD,
  parameter logic [7:0] PREFIX_IY = 8'hFD,
  parameter logic [3:0] XPT_LIMIT = 4'hF
) (
  input  logic       clock,
  input  logic       notReset,
  input  logic [7:0] DataIn,
  input  logic       MemReady,
  input  logic       Hold,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Set_CM1,
  input  logic       P2_Reset_ITABLE,
  output logic       enable,
  output logic [3:0] XPT,
  output logic [3:0] notXPT,
  output logic [7:0] ITABLE,
  output logic [7:0] notITABLE,
  output logic       CM1,
  output logic       PrefixIX,
  output logic       PrefixIY,
  output logic       XptOverrun
);

  // state  | meaning
  // FETCH  | M1 cycle: wait for opcode byte, absorb prefixes
  // EXEC   | executing: XPT steps each unheld cycle
  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t     state_q, state_d;
  logic [3:0] xpt_q, xpt_d;
  logic [7:0] itable_q, itable_d;
  logic       pfx_ix_q, pfx_ix_d;
  logic       pfx_iy_q, pfx_iy_d;
  logic       ovr_q, ovr_d;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q  <= S_FETCH;
      xpt_q    <= 4'h0;
      itable_q <= 8'h00;
      pfx_ix_q <= 1'b0;
      pfx_iy_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpt_q    <= xpt_d;
      itable_q <= itable_d;
      pfx_ix_q <= pfx_ix_d;
      pfx_iy_q <= pfx_iy_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    xpt_d    = xpt_q;
    itable_d = itable_q;
    pfx_ix_d = pfx_ix_q;
    pfx_iy_d = pfx_iy_q;
    ovr_d    = ovr_q;
    unique case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          if (DataIn == PREFIX_IX) begin
            pfx_ix_d = 1'b1;
            pfx_iy_d = 1'b0;
          end else if (DataIn == PREFIX_IY) begin
            pfx_ix_d = 1'b0;
            pfx_iy_d = 1'b1;
          end else begin
            itable_d = DataIn;
            xpt_d    = 4'h0;
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (!Hold) begin
          if (P2_Set_CM1) begin
            state_d  = S_FETCH;
            xpt_d    = 4'h0;
            pfx_ix_d = 1'b0;
            pfx_iy_d = 1'b0;
          end else if (PR_Reset_XPT) begin
            xpt_d = 4'h0;
          end else if (xpt_q == XPT_LIMIT) begin
            // Runaway instruction: flag it and force a clean refetch instead of wrapping.
            ovr_d    = 1'b1;
            state_d  = S_FETCH;
            xpt_d    = 4'h0;
            itable_d = 8'h00;
            pfx_ix_d = 1'b0;
            pfx_iy_d = 1'b0;
          end else begin
            xpt_d = xpt_q + 4'h1;
          end
          if (P2_Reset_ITABLE) itable_d = 8'h00;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign CM1        = (state_q == S_FETCH);
  assign enable     = (state_q == S_EXEC) && !Hold;
  assign XPT        = xpt_q;
  assign notXPT     = ~xpt_q;
  assign ITABLE     = itable_q;
  assign notITABLE  = ~itable_q;
  assign PrefixIX   = pfx_ix_q;
  assign PrefixIY   = pfx_iy_q;
  assign XptOverrun = ovr_q;

endmodule
